// File: rtl/shift_pipe_if.sv
// Request/response bundle of the pipelined shifter: operand side in, result side out.
// master drives requests and consumes results; slave is the shifter.
interface shift_pipe_if #(
  parameter int N     = 64,
  parameter int TAG_W = 5
);
  localparam int K = $clog2(N);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic             word;
  logic [K-1:0]     amt;
  logic [N-1:0]     data_in;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     data_out;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output in_valid, op, word, amt, data_in, tag_in, out_ready,
    input  in_ready, out_valid, data_out, tag_out
  );

  modport slave (
    input  in_valid, op, word, amt, data_in, tag_in, out_ready,
    output in_ready, out_valid, data_out, tag_out
  );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined log shifter (SLL/SRL/SRA/ROR, optional RV64 W-forms), ceil(log2(N)/REG_EVERY) cycles.
// Valid/ready with a per-stage ready chain: bubbles collapse, a full stalled pipe drops in_ready.
module shift_pipe #(
  parameter int N         = 64,
  parameter int REG_EVERY = 2,
  parameter int HAS_WORD  = 1,
  parameter int TAG_W     = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  shift_pipe_if.slave sp
);
  localparam int K = $clog2(N);
  localparam int L = (K + REG_EVERY - 1) / REG_EVERY;
  localparam bit WORD_EN = (HAS_WORD != 0) && (N == 64);

  localparam logic [1:0] OP_SLL = 2'd0;
  localparam logic [1:0] OP_SRA = 2'd2;
  localparam logic [1:0] OP_ROR = 2'd3;

  function automatic logic [N-1:0] rev(input logic [N-1:0] x);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = x[N-1-i];
    return r;
  endfunction

  // Register r holds the result of mux stage r together with its side-band.
  logic [L:1]       v_q;
  logic [L:1]       word_q;
  logic [N-1:0]     d_q   [1:L];
  logic [1:0]       op_q  [1:L];
  logic [K-1:0]     amt_q [1:L];
  logic [TAG_W-1:0] tag_q [1:L];

  // Values presented to register r this cycle.
  logic [L:1]       rdy;
  logic [L:1]       s_v;
  logic [L:1]       s_word;
  logic [N-1:0]     s_d   [1:L];
  logic [1:0]       s_op  [1:L];
  logic [K-1:0]     s_amt [1:L];
  logic [TAG_W-1:0] s_tag [1:L];

  logic [K-1:0] amt_m;
  logic [N-1:0] pre_w;
  logic [N-1:0] pre;
  logic [N-1:0] fin_d;
  logic [N-1:0] cur;
  int           sh;
  logic         unused_sb;

  always_comb begin
    rdy[L] = sp.out_ready || !v_q[L];
    for (int r = L - 1; r >= 1; r--) rdy[r] = rdy[r+1] || !v_q[r];
  end

  assign sp.in_ready = rdy[1] && !rst && !flush;

  if (WORD_EN) begin : g_wpre
    always_comb begin
      amt_m = sp.amt;
      pre_w = sp.data_in;
      if (sp.word) begin
        amt_m[K-1] = 1'b0;
        case (sp.op)
          2'd1:    pre_w = {32'b0, sp.data_in[31:0]};
          2'd2:    pre_w = {{32{sp.data_in[31]}}, sp.data_in[31:0]};
          2'd3:    pre_w = {sp.data_in[31:0], sp.data_in[31:0]};
          default: pre_w = sp.data_in;
        endcase
      end
    end
  end else begin : g_npre
    assign amt_m = sp.amt;
    assign pre_w = sp.data_in;
  end

  // Left shifts reuse the right-shift core by mirroring the operand.
  assign pre = (sp.op == OP_SLL) ? rev(pre_w) : pre_w;

  always_comb begin
    s_v[1]    = sp.in_valid && sp.in_ready;
    s_op[1]   = sp.op;
    s_word[1] = sp.word & WORD_EN;
    s_amt[1]  = amt_m;
    s_tag[1]  = sp.tag_in;
    for (int r = 2; r <= L; r++) begin
      s_v[r]    = v_q[r-1];
      s_op[r]   = op_q[r-1];
      s_word[r] = word_q[r-1];
      s_amt[r]  = amt_q[r-1];
      s_tag[r]  = tag_q[r-1];
    end
  end

  // Level j shifts by 2^j and belongs to stage j/REG_EVERY+1.
  always_comb begin
    cur = pre;
    sh  = 0;
    for (int r = 1; r <= L; r++) s_d[r] = '0;
    for (int j = 0; j < K; j++) begin
      if ((j % REG_EVERY == 0) && (j != 0)) cur = d_q[j / REG_EVERY];
      if (s_amt[j / REG_EVERY + 1][j]) begin
        sh = 1 << j;
        if (s_op[j / REG_EVERY + 1] == OP_ROR)
          cur = (cur >> sh) | (cur << (N - sh));
        else if (s_op[j / REG_EVERY + 1] == OP_SRA)
          cur = $signed(cur) >>> sh;
        else
          cur = cur >> sh;
      end
      if ((j % REG_EVERY == REG_EVERY - 1) || (j == K - 1)) s_d[j / REG_EVERY + 1] = cur;
    end
    if (s_op[L] == OP_SLL) s_d[L] = rev(s_d[L]);
  end

  if (WORD_EN) begin : g_wpost
    assign fin_d = s_word[L] ? {{32{s_d[L][31]}}, s_d[L][31:0]} : s_d[L];
  end else begin : g_npost
    assign fin_d = s_d[L];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      word_q <= '0;
      for (int r = 1; r <= L; r++) begin
        d_q[r]   <= '0;
        op_q[r]  <= '0;
        amt_q[r] <= '0;
        tag_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r <= L; r++) begin
        if (flush)       v_q[r] <= 1'b0;
        else if (rdy[r]) v_q[r] <= s_v[r];
        // Payload only moves with a valid op, so the output holds between results.
        if (rdy[r] && s_v[r]) begin
          d_q[r]    <= (r == L) ? fin_d : s_d[r];
          op_q[r]   <= s_op[r];
          word_q[r] <= s_word[r];
          amt_q[r]  <= s_amt[r];
          tag_q[r]  <= s_tag[r];
        end
      end
    end
  end

  // Side-band of the last register is carried along but not consumed.
  always_comb begin
    unused_sb = 1'b0;
    for (int r = 1; r <= L; r++) unused_sb = unused_sb ^ (^{op_q[r], word_q[r], amt_q[r]});
  end

  assign sp.out_valid = v_q[L];
  assign sp.data_out  = d_q[L];
  assign sp.tag_out   = tag_q[L];
endmodule
